// File: rtl/ibuf_pkg.sv
// ibuf_pkg: definitions shared by the IBUF stream shuffler files.
//   - shuffle mode encodings carried on in_mode
//   - skid-stage state encoding, also exported on the top's debug port
//   - helpers that derive lanes-per-bank (RATIO) and elements-per-beat (E)
package ibuf_pkg;

  localparam logic [1:0] IBUF_SHUF_TRANSPOSE = 2'd0;
  localparam logic [1:0] IBUF_SHUF_LINEAR    = 2'd1;
  localparam logic [1:0] IBUF_SHUF_BCAST     = 2'd2;
  // Code 3 is reserved; it is decoded as LINEAR.

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,  // no beat held
    SKID_ONE   = 2'd1,  // main register holds a beat
    SKID_TWO   = 2'd2   // main and skid both hold a beat
  } skid_state_t;

  // Lanes per bank per beat.
  function automatic int ibuf_ratio(input int ddr_bw, input int num_banks, input int data_w);
    return ddr_bw / (num_banks * data_w);
  endfunction

  // Elements per beat.
  function automatic int ibuf_nelem(input int num_banks, input int ratio);
    return num_banks * ratio;
  endfunction

endpackage

// File: rtl/ibuf_stream_shuffler_if.sv
// ibuf_stream_shuffler_if: input and output streams of the IBUF shuffler.
//   in_*  : DDR beat plus shuffle controls (mode, base rotation, element count)
//   out_* : shuffled beat, burst-last flag and per-bank write enables
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge;
// ready may be high or low independently of valid.
// Modports: master drives the input side and accepts output (the producer /
// consumer environment); slave is the shuffler itself.
interface ibuf_stream_shuffler_if #(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int ROT_W         = 3,
  parameter int NELEM_W       = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DDR_BANDWIDTH-1:0] in_data;
  logic                     in_last;
  logic [1:0]               in_mode;
  logic [ROT_W-1:0]         in_rot;
  logic [NELEM_W-1:0]       in_nelem;
  logic                     out_valid;
  logic                     out_ready;
  logic [DDR_BANDWIDTH-1:0] out_data;
  logic                     out_last;
  logic [NUM_BANKS-1:0]     out_bank_mask;

  modport master (
    output in_valid, in_data, in_last, in_mode, in_rot, in_nelem, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_bank_mask
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, in_rot, in_nelem, out_ready,
    output in_ready, out_valid, out_data, out_last, out_bank_mask
  );
endinterface

// File: rtl/ibuf_shuf_perm.sv
// ibuf_shuf_perm: combinational beat permutation.
//   in_data  : DDR beat, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_mode  : TRANSPOSE / LINEAR / BCAST (3 = LINEAR)
//   rot      : effective bank rotation (TRANSPOSE only)
//   in_nelem : valid element count, 0 means all
//   out_data : bank j lane i at [(j*RATIO+i)*DATA_WIDTH +: DATA_WIDTH]
//   out_mask : bank has at least one valid lane
module ibuf_shuf_perm
  import ibuf_pkg::*;
#(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RATIO         = ibuf_ratio(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH),
  parameter int NELEM         = ibuf_nelem(NUM_BANKS, RATIO),
  parameter int ROT_W         = $clog2(NUM_BANKS),
  parameter int NELEM_W       = $clog2(NELEM)
) (
  input  logic [DDR_BANDWIDTH-1:0] in_data,
  input  logic [1:0]               in_mode,
  input  logic [ROT_W-1:0]         rot,
  input  logic [NELEM_W-1:0]       in_nelem,
  output logic [DDR_BANDWIDTH-1:0] out_data,
  output logic [NUM_BANKS-1:0]     out_mask
);

  always_comb begin
    int n_eff;
    int src;
    out_data = '0;
    out_mask = '0;
    n_eff    = (in_nelem == '0) ? NELEM : int'(in_nelem);
    src      = 0;
    for (int j = 0; j < NUM_BANKS; j++) begin
      for (int i = 0; i < RATIO; i++) begin
        case (in_mode)
          IBUF_SHUF_TRANSPOSE: src = i * NUM_BANKS + ((j + int'(rot)) % NUM_BANKS);
          IBUF_SHUF_BCAST:     src = i;
          default:             src = j * RATIO + i;
        endcase
        // Validity follows the source element, so lanes past the count read
        // as zero and BCAST enables the same lanes in every bank.
        if (src < n_eff) begin
          out_data[(j*RATIO+i)*DATA_WIDTH +: DATA_WIDTH] = in_data[src*DATA_WIDTH +: DATA_WIDTH];
          out_mask[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ibuf_stream_shuffler.sv
// ibuf_stream_shuffler: reorders DDR read beats into IBUF bank slices.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : input/output streams (see ibuf_stream_shuffler_if)
//   dbg_state    : skid-stage state for observation
// Output stage is a main register plus one skid entry; in_ready comes straight
// from a flop, so out_ready never reaches in_ready combinationally.
module ibuf_stream_shuffler
  import ibuf_pkg::*;
#(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RATIO         = ibuf_ratio(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH),
  parameter bit ROT_AUTO      = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ibuf_stream_shuffler_if.slave   bus,
  output skid_state_t             dbg_state
);

  localparam int NELEM   = ibuf_nelem(NUM_BANKS, RATIO);
  localparam int ROT_W   = $clog2(NUM_BANKS);
  localparam int NELEM_W = $clog2(NELEM);

  skid_state_t              state, state_next;
  logic                     in_ready_q;
  logic [ROT_W-1:0]         beat_cnt;
  logic [ROT_W-1:0]         rot_eff;
  logic [DDR_BANDWIDTH-1:0] perm_data;
  logic [NUM_BANKS-1:0]     perm_mask;
  logic [DDR_BANDWIDTH-1:0] main_data, skid_data;
  logic [NUM_BANKS-1:0]     main_mask, skid_mask;
  logic                     main_last, skid_last;
  logic                     main_valid, accept, drain;
  logic                     load_main_in, load_main_skid, load_skid;

  // Rotation wraps naturally in ROT_W bits since NUM_BANKS is a power of two.
  assign rot_eff = ROT_AUTO ? (bus.in_rot + beat_cnt) : bus.in_rot;

  ibuf_shuf_perm #(
    .DDR_BANDWIDTH(DDR_BANDWIDTH),
    .NUM_BANKS    (NUM_BANKS),
    .DATA_WIDTH   (DATA_WIDTH),
    .RATIO        (RATIO),
    .NELEM        (NELEM),
    .ROT_W        (ROT_W),
    .NELEM_W      (NELEM_W)
  ) u_perm (
    .in_data (bus.in_data),
    .in_mode (bus.in_mode),
    .rot     (rot_eff),
    .in_nelem(bus.in_nelem),
    .out_data(perm_data),
    .out_mask(perm_mask)
  );

  assign main_valid = (state != SKID_EMPTY);
  assign accept     = bus.in_valid && in_ready_q;
  assign drain      = main_valid && bus.out_ready;

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_valid;
  assign bus.out_data      = main_data;
  assign bus.out_last      = main_last;
  assign bus.out_bank_mask = main_mask;
  assign dbg_state         = state;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = SKID_ONE;
        end
      end
      SKID_ONE: begin
        // A beat arriving while main drains replaces it directly: no bubble.
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = SKID_TWO;
        end else if (drain) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          load_main_skid = 1'b1;
          state_next     = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SKID_EMPTY;
      in_ready_q <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != SKID_TWO);
      if (accept) begin
        beat_cnt <= bus.in_last ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data <= '0;
      main_mask <= '0;
      main_last <= 1'b0;
      skid_data <= '0;
      skid_mask <= '0;
      skid_last <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= perm_data;
        main_mask <= perm_mask;
        main_last <= bus.in_last;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_mask <= skid_mask;
        main_last <= skid_last;
      end
      if (load_skid) begin
        skid_data <= perm_data;
        skid_mask <= perm_mask;
        skid_last <= bus.in_last;
      end
    end
  end

endmodule
